// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// UART_TX_ARB_HDR_EN adds the HDR state (one header byte per packet).
package uart_pkg;

`ifdef UART_TX_ARB_HDR_EN
  typedef enum logic [1:0] {
    IDLE,
    ARB,
    HDR,
    PASS
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE,
    ARB,
    PASS
  } state_t;
`endif

  localparam logic [7:0] HDR_BASE = 8'hA0;
  localparam int BPS = 115200;
  localparam int CLK_FREQ = 50000000;

endpackage

// File: rtl/uart_tx_arb_rr_arbiter.sv
// Round-robin pick: first request after the last granted index.
// Purely combinational; grant is one-hot or zero.
module rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    idx
);

  // Scan from last+1 wrapping around; the first hit wins.
  always_comb begin
    int j;
    grant = '0;
    idx = '0;
    j = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      j = int'(last) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (req[j] && grant == '0) begin
        grant[j] = 1'b1;
        idx = j[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Packet-granular round-robin arbiter feeding the UART send FIFO.
// Define UART_TX_ARB_HDR_EN to prefix each packet with 8'hA0|id.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int HEADROOM = 3,
  parameter int TIMEOUT = 1023
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [N_REQ-1:0]      REQ_VALID,
  input  logic [N_REQ-1:0]      REQ_LAST,
  output logic [N_REQ-1:0]      REQ_READY,
  input  logic [N_REQ*8-1:0]    REQ_DATA,
  output logic                  WRREQ,
  output logic [7:0]            DIN,
  input  logic [ADDR_WIDTH-1:0] USEDW_SEND,
  output logic [N_REQ-1:0]      GRANT,
  output logic                  BUSY,
  output logic                  TMO
);

  localparam int IW = $clog2(N_REQ);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_WIDTH:0] LIMIT =
    (ADDR_WIDTH+1)'((1 << ADDR_WIDTH) - HEADROOM);
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT - 1);
  localparam logic [IW-1:0] LAST_RST = IW'(N_REQ - 1);

  state_t state, state_n;
  logic [IW-1:0] last;
  logic [WW-1:0] wd;
  logic [N_REQ-1:0] arb_grant;
  logic [IW-1:0] arb_idx;
  logic [N_REQ-1:0] ready;
  logic space, xfer, hdr_wr, wd_inc, tmo_hit;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req   (REQ_VALID),
    .last  (last),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  assign space = {1'b0, USEDW_SEND} < LIMIT;
  assign REQ_READY = ready;
  assign BUSY = (state != IDLE);

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else state <= state_n;
  end

  // Next state, handshake and strobe decode.
  always_comb begin
    state_n = state;
    ready = '0;
    xfer = 1'b0;
    hdr_wr = 1'b0;
    wd_inc = 1'b0;
    tmo_hit = 1'b0;
    unique case (state)
      IDLE: if (|REQ_VALID) state_n = ARB;
      ARB: begin
        if (|arb_grant) begin
`ifdef UART_TX_ARB_HDR_EN
          state_n = HDR;
`else
          state_n = PASS;
`endif
        end else begin
          state_n = IDLE;
        end
      end
`ifdef UART_TX_ARB_HDR_EN
      HDR: begin
        if (space) begin
          hdr_wr = 1'b1;
          state_n = PASS;
        end
      end
`endif
      PASS: begin
        ready[last] = space;
        if (space && REQ_VALID[last]) begin
          xfer = 1'b1;
          if (REQ_LAST[last]) state_n = IDLE;
        end else if (space) begin
          if (wd == WD_MAX) begin
            tmo_hit = 1'b1;
            state_n = IDLE;
          end else begin
            wd_inc = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Grant, pointer, watchdog and registered FIFO write.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      GRANT <= '0;
      last <= LAST_RST;
      wd <= '0;
      WRREQ <= 1'b0;
      DIN <= 8'h00;
      TMO <= 1'b0;
    end else begin
      WRREQ <= xfer | hdr_wr;
      TMO <= tmo_hit;
      if (xfer) DIN <= REQ_DATA[8*int'(last) +: 8];
      else if (hdr_wr) DIN <= HDR_BASE | 8'(last);
      if (state == ARB && |arb_grant) begin
        GRANT <= arb_grant;
        last <= arb_idx;
      end else if (state_n == IDLE) begin
        GRANT <= '0;
      end
      if (state != PASS || xfer || tmo_hit) wd <= '0;
      else if (wd_inc) wd <= wd + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb (4 requesters, TIMEOUT=16).
// Expected byte streams follow UART_TX_ARB_HDR_EN.
module tb_uart_tx_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req_valid, req_last, req_ready;
  logic [31:0] req_data;
  logic wrreq, busy, tmo;
  logic [7:0] din;
  logic [7:0] usedw = 8'd0;
  logic [3:0] grant;

  int vecs = 0;
  int errs = 0;

  logic [7:0] sdata [4][8];
  int slen [4];
  int sptr [4];
  bit slast [4];
  logic [3:0] hs_q = '0;
  logic [7:0] outq [$];

`ifdef UART_TX_ARB_HDR_EN
  localparam bit HDR = 1'b1;
`else
  localparam bit HDR = 1'b0;
`endif

  uart_tx_arb #(
    .N_REQ(4), .ADDR_WIDTH(8), .HEADROOM(3), .TIMEOUT(16)
  ) dut (
    .CLK(clk), .RST(rst),
    .REQ_VALID(req_valid), .REQ_LAST(req_last),
    .REQ_READY(req_ready), .REQ_DATA(req_data),
    .WRREQ(wrreq), .DIN(din), .USEDW_SEND(usedw),
    .GRANT(grant), .BUSY(busy), .TMO(tmo)
  );

  always #5 clk = ~clk;

  task automatic drive_src();
    for (int i = 0; i < 4; i++) begin
      logic v;
      v = sptr[i] < slen[i];
      req_valid[i] = v;
      req_last[i] = v && slast[i] && (sptr[i] == slen[i] - 1);
      req_data[i*8 +: 8] = v ? sdata[i][sptr[i]] : 8'h00;
    end
  endtask

  task automatic load(input int i, input int n, input bit l,
                      input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] b2, input logic [7:0] b3);
    sdata[i][0] = b0;
    sdata[i][1] = b1;
    sdata[i][2] = b2;
    sdata[i][3] = b3;
    slen[i] = n;
    slast[i] = l;
    sptr[i] = 0;
    drive_src();
  endtask

  always @(negedge clk) hs_q = req_valid & req_ready;

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 4; i++) if (hs_q[i]) sptr[i]++;
    hs_q = '0;
    drive_src();
  end

  always @(negedge clk) if (wrreq === 1'b1) outq.push_back(din);

  task automatic drain(input int n);
    int c;
    c = 0;
    while (!(outq.size() >= n && req_valid == 4'b0 && busy === 1'b0)
           && c < 300) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    vecs++;
    if (grant !== 4'b0) begin
      errs++; $display("FAIL rst_grant got %b want 0000", grant);
    end
    vecs++;
    if (req_ready !== 4'b0) begin
      errs++; $display("FAIL rst_ready got %b want 0000", req_ready);
    end
    vecs++;
    if (wrreq !== 1'b0) begin
      errs++; $display("FAIL rst_wrreq got %b want 0", wrreq);
    end
    vecs++;
    if (din !== 8'h00) begin
      errs++; $display("FAIL rst_din got %h want 00", din);
    end
    vecs++;
    if (tmo !== 1'b0 || busy !== 1'b0) begin
      errs++; $display("FAIL rst_tmo_busy got %b%b want 00", tmo, busy);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [7:0] exp [$];
    outq.delete();
    if (HDR) exp = '{8'hA0, 8'h11, 8'h12, 8'h13,
                     8'hA2, 8'h21, 8'h22, 8'h23};
    else exp = '{8'h11, 8'h12, 8'h13, 8'h21, 8'h22, 8'h23};
    load(0, 3, 1'b1, 8'h11, 8'h12, 8'h13, 8'h00);
    load(2, 3, 1'b1, 8'h21, 8'h22, 8'h23, 8'h00);
    drain(exp.size());
    vecs++;
    if (outq.size() != exp.size()) begin
      errs++;
      $display("FAIL rr_count got %0d want %0d", outq.size(), exp.size());
    end
    for (int k = 0; k < exp.size() && k < outq.size(); k++) begin
      vecs++;
      if (outq[k] !== exp[k]) begin
        errs++;
        $display("FAIL rr_byte%0d got %h want %h", k, outq[k], exp[k]);
      end
    end
  endtask

  task automatic test_space();
    int c;
    usedw = 8'd253;
    load(0, 1, 1'b1, 8'h31, 8'h00, 8'h00, 8'h00);
    c = 0;
    while (grant !== 4'b0001 && c < 20) begin
      @(negedge clk);
      c++;
    end
    vecs++;
    if (grant !== 4'b0001) begin
      errs++; $display("FAIL sp_grant got %b want 0001", grant);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vecs++;
      if (req_ready !== 4'b0 || wrreq !== 1'b0 || busy !== 1'b1) begin
        errs++;
        $display("FAIL sp_stall%0d got rdy=%b wr=%b busy=%b want 0000 0 1",
                 k, req_ready, wrreq, busy);
      end
    end
    #2 usedw = 8'd252;
    #1;
    c = 0;
    while (req_ready !== 4'b0001 && c < 5) begin
      @(negedge clk);
      c++;
    end
    vecs++;
    if (req_ready !== 4'b0001 || c != (HDR ? 1 : 0)) begin
      errs++;
      $display("FAIL sp_ready got %b after %0d want 0001 after %0d",
               req_ready, c, HDR ? 1 : 0);
    end
    @(negedge clk);
    vecs++;
    if (wrreq !== 1'b1 || din !== 8'h31 || grant !== 4'b0) begin
      errs++;
      $display("FAIL sp_write got wr=%b din=%h g=%b want 1 31 0000",
               wrreq, din, grant);
    end
    usedw = 8'd0;
    drain(0);
  endtask

  task automatic test_timeout();
    int c;
    logic [7:0] exp [$];
    load(1, 1, 1'b0, 8'h51, 8'h00, 8'h00, 8'h00);
    load(2, 1, 1'b1, 8'h52, 8'h00, 8'h00, 8'h00);
    c = 0;
    while (!(wrreq === 1'b1 && din === 8'h51) && c < 20) begin
      @(negedge clk);
      c++;
    end
    vecs++;
    if (grant !== 4'b0010 || wrreq !== 1'b1) begin
      errs++;
      $display("FAIL to_first got g=%b wr=%b want 0010 1", grant, wrreq);
    end
    c = 0;
    while (c < 40) begin
      @(negedge clk);
      c++;
      if (tmo === 1'b1) break;
    end
    vecs++;
    if (c != 16 || tmo !== 1'b1) begin
      errs++; $display("FAIL to_delay got %0d want 16", c);
    end
    vecs++;
    if (grant !== 4'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL to_revoke got g=%b busy=%b want 0000 0", grant, busy);
    end
    @(negedge clk);
    vecs++;
    if (tmo !== 1'b0) begin
      errs++; $display("FAIL to_pulse got %b want 0", tmo);
    end
    c = 0;
    while (grant === 4'b0 && c < 10) begin
      @(negedge clk);
      c++;
    end
    vecs++;
    if (grant !== 4'b0100) begin
      errs++; $display("FAIL to_next got %b want 0100", grant);
    end
    outq.delete();
    if (HDR) exp = '{8'hA2, 8'h52};
    else exp = '{8'h52};
    drain(exp.size());
    vecs++;
    if (outq.size() != exp.size() || outq[exp.size()-1] !== 8'h52) begin
      errs++;
      $display("FAIL to_req2 got n=%0d want n=%0d ending 52",
               outq.size(), exp.size());
    end
  endtask

  task automatic test_header();
    logic [7:0] exp [$];
    outq.delete();
    if (HDR) exp = '{8'hA3, 8'h55};
    else exp = '{8'h55};
    load(3, 1, 1'b1, 8'h55, 8'h00, 8'h00, 8'h00);
    drain(exp.size());
    vecs++;
    if (outq.size() != exp.size()) begin
      errs++;
      $display("FAIL hdr_count got %0d want %0d", outq.size(), exp.size());
    end
    for (int k = 0; k < exp.size() && k < outq.size(); k++) begin
      vecs++;
      if (outq[k] !== exp[k]) begin
        errs++;
        $display("FAIL hdr_byte%0d got %h want %h", k, outq[k], exp[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int c, nwr;
    logic [7:0] exp [$];
    load(3, 4, 1'b1, 8'h61, 8'h62, 8'h63, 8'h64);
    c = 0;
    while (!(wrreq === 1'b1 && din === 8'h61) && c < 20) begin
      @(negedge clk);
      c++;
    end
    vecs++;
    if (req_ready !== 4'b1000) begin
      errs++; $display("FAIL rm_mid got %b want 1000", req_ready);
    end
    #2 rst = 1'b1;
    #1;
    vecs++;
    if (grant !== 4'b0 || req_ready !== 4'b0 || wrreq !== 1'b0 ||
        din !== 8'h00 || tmo !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL rm_clear got g=%b r=%b wr=%b din=%h t=%b b=%b want 0",
               grant, req_ready, wrreq, din, tmo, busy);
    end
    nwr = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (wrreq !== 1'b0) nwr++;
    end
    vecs++;
    if (nwr != 0) begin
      errs++; $display("FAIL rm_nowr got %0d want 0", nwr);
    end
    load(3, 1, 1'b1, 8'h65, 8'h00, 8'h00, 8'h00);
    load(0, 1, 1'b1, 8'h71, 8'h00, 8'h00, 8'h00);
    @(posedge clk);
    #2;
    outq.delete();
    rst = 1'b0;
    c = 0;
    while (grant === 4'b0 && c < 10) begin
      @(negedge clk);
      c++;
    end
    vecs++;
    if (grant !== 4'b0001) begin
      errs++; $display("FAIL rm_first got %b want 0001", grant);
    end
    if (HDR) exp = '{8'hA0, 8'h71, 8'hA3, 8'h65};
    else exp = '{8'h71, 8'h65};
    drain(exp.size());
    vecs++;
    if (outq.size() != exp.size()) begin
      errs++;
      $display("FAIL rm_count got %0d want %0d", outq.size(), exp.size());
    end
    for (int k = 0; k < exp.size() && k < outq.size(); k++) begin
      vecs++;
      if (outq[k] !== exp[k]) begin
        errs++;
        $display("FAIL rm_byte%0d got %h want %h", k, outq[k], exp[k]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      slen[i] = 0;
      sptr[i] = 0;
      slast[i] = 1'b0;
      for (int k = 0; k < 8; k++) sdata[i][k] = 8'h00;
    end
    drive_src();
    test_reset();
    test_round_robin();
    test_space();
    test_timeout();
    test_header();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
